// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-ported, variable-latency unified memory between the
//   instruction-fetch port (F stage) and the data port (M stage). Only one
//   transaction is outstanding at a time. Each port receives a one-cycle ready
//   pulse when its transaction completes. The hazard unit inverts these pulses
//   to produce fetch and memory stalls.
//
// Arbitration:
//   Requests are sampled only in IDLE. Data wins over fetch. A completed
//   transaction always returns to IDLE for one cycle, so two back-to-back
//   transactions are separated by one bubble cycle with mem_req low.
//
// Optional feature:
//   MEMARB_STARVE_GUARD_EN - when defined, a saturating streak counter counts
//   data grants made while fetch is waiting. Once the counter reaches STREAK,
//   the next grant goes to fetch. When undefined, data priority is strict and
//   fetch can starve.
//
// Ports:
//   clk       - single clock, all state on the rising edge
//   reset     - asynchronous, active-low reset
//   ireq      - fetch request, held until iready
//   iaddr     - fetch address
//   irdata    - fetch data, zero unless iready
//   iready    - one-cycle fetch completion pulse
//   dreq      - data request, held until dready
//   dwe       - data write enable
//   daddr     - data address
//   dwdata    - store data
//   drdata    - load data, zero unless dready
//   dready    - one-cycle data completion pulse
//   mem_req   - memory request, held until mem_ack
//   mem_we    - memory write enable
//   mem_addr  - memory address
//   mem_wdata - memory write data
//   mem_rdata - memory read data, valid with mem_ack
//   mem_ack   - one-cycle memory completion
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          iready,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          force_fetch;
  logic          grant_d;
  logic          grant_i;

  // In IDLE, data wins unless the starvation guard forces a fetch. The guard
  // can only assert while ireq is high, so a forced grant always has a fetch
  // to serve.
  assign grant_d = (state_q == IDLE) && dreq && !force_fetch;
  assign grant_i = (state_q == IDLE) && ireq && !grant_d;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STREAK + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(STREAK);

  logic [CNT_W-1:0] streak_q, streak_d;

  assign force_fetch = ireq && (streak_q == STREAK_MAX);

  // The counter grows only while fetch is actually waiting. Any fetch grant,
  // or a data grant with no fetch pending, ends the streak.
  always_comb begin
    streak_d = streak_q;
    if (grant_d) begin
      if (!ireq) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + CNT_W'(1);
      end
    end else if (grant_i) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  // Next-state logic. The winning port's request fields are captured at the
  // grant edge. The memory port is driven only from these registers, so a
  // requester that changes or drops its inputs mid-transaction has no effect.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = DBUSY;
          we_d    = dwe;
          addr_d  = daddr;
          wdata_d = dwdata;
        end else if (grant_i) begin
          state_d = IBUSY;
          we_d    = 1'b0;
          addr_d  = iaddr;
          wdata_d = '0;
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // The request is held for as long as a transaction is owned. An ack seen in
  // IDLE matches neither busy state, so it is ignored.
  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign iready = (state_q == IBUSY) && mem_ack;
  assign dready = (state_q == DBUSY) && mem_ack;
  assign irdata = iready ? mem_rdata : '0;
  assign drdata = dready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. The bench acts as both requesters and
// as the memory. Inputs change 1ns after the rising edge. Outputs are checked
// 1ns after that, once the combinational ready and rdata paths have settled.
// The starvation-guard section follows MEMARB_STARVE_GUARD_EN, so the same
// bench serves both builds.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int STREAK = 4;

  logic          clk;
  logic          reset;
  logic          ireq;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] irdata;
  logic          iready;
  logic          dreq;
  logic          dwe;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic [DW-1:0] drdata;
  logic          dready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  int total;
  int bad;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .STREAK(STREAK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ireq(ireq),
    .iaddr(iaddr),
    .irdata(irdata),
    .iready(iready),
    .dreq(dreq),
    .dwe(dwe),
    .daddr(daddr),
    .dwdata(dwdata),
    .drdata(drdata),
    .dready(dready),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  // 10ns clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advances to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives both requester ports in one step
  task automatic applyStimulus(input logic i_req, input logic [AW-1:0] i_addr,
                               input logic d_req, input logic d_we,
                               input logic [AW-1:0] d_addr,
                               input logic [DW-1:0] d_wdata);
    ireq   = i_req;
    iaddr  = i_addr;
    dreq   = d_req;
    dwe    = d_we;
    daddr  = d_addr;
    dwdata = d_wdata;
  endtask

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic exp_fetch;

    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Reset state
    tick();
    tick();
    #1;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_iready", 32'(iready), 32'd0);
    checkOutput("rst_dready", 32'(dready), 32'd0);
    checkOutput("rst_irdata", irdata, 32'h0);
    checkOutput("rst_drdata", drdata, 32'h0);
    reset = 1'b1;

    // Reset asserted mid-DBUSY drops mem_req at once
    $display("[TB] reset mid-transaction");
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h20, 32'h11223344);
    tick();
    #1;
    checkOutput("mid_busy_req", 32'(mem_req), 32'd1);
    checkOutput("mid_busy_addr", mem_addr, 32'h20);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_req", 32'(mem_req), 32'd0);
    checkOutput("mid_rst_we", 32'(mem_we), 32'd0);
    checkOutput("mid_rst_addr", mem_addr, 32'h0);
    checkOutput("mid_rst_wdata", mem_wdata, 32'h0);
    reset = 1'b1;
    applyStimulus(1'b1, 32'h00400000, 1'b0, 1'b0, '0, '0);

    // Fetch granted one cycle later; ack arrives in the third busy cycle
    $display("[TB] fetch with ack latency 3");
    tick();
    #1;
    checkOutput("f_req", 32'(mem_req), 32'd1);
    checkOutput("f_addr", mem_addr, 32'h00400000);
    checkOutput("f_we", 32'(mem_we), 32'd0);
    checkOutput("f_iready_c1", 32'(iready), 32'd0);
    tick();
    #1;
    checkOutput("f_req_c2", 32'(mem_req), 32'd1);
    checkOutput("f_iready_c2", 32'(iready), 32'd0);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h8C080004;
    #1;
    checkOutput("f_iready_c3", 32'(iready), 32'd1);
    checkOutput("f_irdata", irdata, 32'h8C080004);
    checkOutput("f_dready_c3", 32'(dready), 32'd0);
    checkOutput("f_drdata_c3", drdata, 32'h0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    ireq      = 1'b0;
    #1;
    checkOutput("f_iready_after", 32'(iready), 32'd0);
    checkOutput("f_req_after", 32'(mem_req), 32'd0);

    // An ack in IDLE is ignored
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    #1;
    checkOutput("idle_ack_iready", 32'(iready), 32'd0);
    checkOutput("idle_ack_dready", 32'(dready), 32'd0);
    checkOutput("idle_ack_drdata", drdata, 32'h0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    checkOutput("idle_ack_req", 32'(mem_req), 32'd0);

    // Simultaneous requests: the store wins, then the fetch follows after one bubble
    $display("[TB] simultaneous fetch and store");
    applyStimulus(1'b1, 32'h00400004, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    #1;
    checkOutput("sim_req", 32'(mem_req), 32'd1);
    checkOutput("sim_we", 32'(mem_we), 32'd1);
    checkOutput("sim_addr", mem_addr, 32'h10);
    checkOutput("sim_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ack = 1'b1;
    #1;
    checkOutput("sim_dready", 32'(dready), 32'd1);
    checkOutput("sim_iready_d", 32'(iready), 32'd0);
    tick();
    mem_ack = 1'b0;
    dreq    = 1'b0;
    #1;
    checkOutput("sim_bubble", 32'(mem_req), 32'd0);
    checkOutput("sim_dready_off", 32'(dready), 32'd0);
    tick();
    #1;
    checkOutput("sim_f_req", 32'(mem_req), 32'd1);
    checkOutput("sim_f_we", 32'(mem_we), 32'd0);
    checkOutput("sim_f_addr", mem_addr, 32'h00400004);
    checkOutput("sim_f_wdata", mem_wdata, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    #1;
    checkOutput("sim_f_iready", 32'(iready), 32'd1);
    checkOutput("sim_f_irdata", irdata, 32'h12345678);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    ireq      = 1'b0;

    // Back-to-back loads with immediate ack: mem_req 1,0,1,0
    $display("[TB] back-to-back loads");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h100, '0);
    tick();
    #1;
    checkOutput("b2b_req0", 32'(mem_req), 32'd1);
    checkOutput("b2b_addr0", mem_addr, 32'h100);
    mem_ack   = 1'b1;
    mem_rdata = 32'h000000A1;
    #1;
    checkOutput("b2b_dready0", 32'(dready), 32'd1);
    checkOutput("b2b_drdata0", drdata, 32'h000000A1);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    daddr     = 32'h104;
    #1;
    checkOutput("b2b_req1", 32'(mem_req), 32'd0);
    checkOutput("b2b_dready1", 32'(dready), 32'd0);
    tick();
    #1;
    checkOutput("b2b_req2", 32'(mem_req), 32'd1);
    checkOutput("b2b_addr2", mem_addr, 32'h104);
    mem_ack   = 1'b1;
    mem_rdata = 32'h000000A2;
    #1;
    checkOutput("b2b_dready2", 32'(dready), 32'd1);
    checkOutput("b2b_drdata2", drdata, 32'h000000A2);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    dreq      = 1'b0;
    #1;
    checkOutput("b2b_req3", 32'(mem_req), 32'd0);

    // Requester drops dreq after grant: transaction still completes
    $display("[TB] dreq dropped after grant");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h200, '0);
    tick();
    dreq = 1'b0;
    #1;
    checkOutput("drop_req_c1", 32'(mem_req), 32'd1);
    tick();
    #1;
    checkOutput("drop_req_c2", 32'(mem_req), 32'd1);
    checkOutput("drop_dready_c2", 32'(dready), 32'd0);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h00000055;
    #1;
    checkOutput("drop_dready", 32'(dready), 32'd1);
    checkOutput("drop_drdata", drdata, 32'h00000055);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    checkOutput("drop_idle_req", 32'(mem_req), 32'd0);
    tick();
    #1;
    checkOutput("drop_stays_idle", 32'(mem_req), 32'd0);

    // Both requests held continuously with an immediately acking memory
    $display("[TB] continuous contention");
    applyStimulus(1'b1, 32'h00400100, 1'b1, 1'b0, 32'h300, '0);
    for (int t = 0; t < 10; t++) begin
`ifdef MEMARB_STARVE_GUARD_EN
      exp_fetch = ((t % 5) == 4);
`else
      exp_fetch = 1'b0;
`endif
      tick();
      #1;
      checkOutput($sformatf("cont_req_%0d", t), 32'(mem_req), 32'd1);
      checkOutput($sformatf("cont_addr_%0d", t), mem_addr,
                  exp_fetch ? 32'h00400100 : 32'h300);
      mem_ack   = 1'b1;
      mem_rdata = 32'h0000F000 + 32'(t);
      #1;
      checkOutput($sformatf("cont_iready_%0d", t), 32'(iready), 32'(exp_fetch));
      checkOutput($sformatf("cont_dready_%0d", t), 32'(dready), 32'(!exp_fetch));
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      #1;
      checkOutput($sformatf("cont_bubble_%0d", t), 32'(mem_req), 32'd0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
